fifo_sync_xpm_intel: RTL and testbench



---
 rtl/fifo_sync_xpm_intel_if.sv | 31 +++
 rtl/fifo_sync_xpm_intel.sv | 96 +++++++++
 tb/tb_fifo_sync_xpm_intel.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_xpm_intel_if.sv
// Push/pop bundle of the show-ahead receive FIFO.
// master drives the requests; slave is the FIFO side.
interface fifo_sync_xpm_intel_if #(
    parameter int NUMWORDS   = 16384,
    parameter int DATA_WIDTH = 64
);
    localparam int CW = $clog2(NUMWORDS) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         usedw;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, empty, full,
        input  usedw, almost_full, almost_empty
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, empty, full,
        output usedw, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_sync_xpm_intel.sv
// Single-clock show-ahead FIFO: block RAM, RAM read register
// and output stage; occupancy counts every stage.
module fifo_sync_xpm_intel #(
    parameter int NUMWORDS           = 16384,
    parameter int DATA_WIDTH         = 64,
    parameter int ALMOST_FULL_LEVEL  = NUMWORDS - 8,
    parameter int ALMOST_EMPTY_LEVEL = 8
) (
    input logic                   clk,
    input logic                   rst,
    fifo_sync_xpm_intel_if.slave  s_if
);
    localparam int AW = $clog2(NUMWORDS);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [NUMWORDS];

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_vld;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_vld;
    logic                  r_empty;
    logic [CW-1:0]         r_usedw;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_ram_ne;
    logic                  w_s1_load;
    logic                  w_s2_load;
    logic                  w_s1_vld_nxt;
    logic                  w_dout_vld_nxt;
    logic [CW-1:0]         w_cnt_nxt;

    // Accept decisions and prefetch advance, from pre-edge state.
    always_comb begin
        w_push    = ~rst & s_if.wr_en & ~r_full;
        w_pop     = ~rst & s_if.rd_en & r_dout_vld;
        w_ram_ne  = (r_wr_ptr != r_rd_ptr);
        w_s2_load = r_s1_vld & (~r_dout_vld | w_pop);
        w_s1_load = ~rst & w_ram_ne & (~r_s1_vld | w_s2_load);
        w_s1_vld_nxt   = w_s1_load | (r_s1_vld & ~w_s2_load);
        w_dout_vld_nxt = w_s2_load | (r_dout_vld & ~w_pop);
        w_cnt_nxt = r_usedw + CW'(w_push) - CW'(w_pop);
    end

    // RAM write port and registered read into stage 1.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= s_if.din;
        if (w_s1_load)
            r_s1_data <= r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointers, stage valids, output word and count/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_s1_vld   <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_empty    <= 1'b1;
            r_usedw    <= '0;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_s1_load)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_s2_load)
                r_dout <= r_s1_data;
            r_s1_vld   <= w_s1_vld_nxt;
            r_dout_vld <= w_dout_vld_nxt;
            r_empty    <= ~w_dout_vld_nxt;
            r_usedw    <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == CW'(NUMWORDS));
            r_af       <= (w_cnt_nxt >= CW'(ALMOST_FULL_LEVEL));
            r_ae       <= (w_cnt_nxt <= CW'(ALMOST_EMPTY_LEVEL));
        end
    end

    assign s_if.dout         = r_dout;
    assign s_if.dout_valid   = r_dout_vld;
    assign s_if.empty        = r_empty;
    assign s_if.full         = r_full;
    assign s_if.usedw        = r_usedw;
    assign s_if.almost_full  = r_af;
    assign s_if.almost_empty = r_ae;
endmodule

// File: tb/tb_fifo_sync_xpm_intel.sv
// Directed bench for the show-ahead FIFO, 16 x 16 build.
// Expected values are hand-derived per scenario.
module tb_fifo_sync_xpm_intel;
    localparam int N  = 16;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fifo_sync_xpm_intel_if #(.NUMWORDS(N), .DATA_WIDTH(DW)) bus ();

    fifo_sync_xpm_intel #(
        .NUMWORDS   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_dout"},  32'(bus.dout), 0);
        chk({tag, "_valid"}, 32'(bus.dout_valid), 0);
        chk({tag, "_empty"}, 32'(bus.empty), 1);
        chk({tag, "_full"},  32'(bus.full), 0);
        chk({tag, "_usedw"}, 32'(bus.usedw), 0);
        chk({tag, "_ae"},    32'(bus.almost_empty), 1);
        chk({tag, "_af"},    32'(bus.almost_full), 0);
    endtask

    initial begin
        logic [15:0] exp_q [$];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        #2;
        chk_rst_vals("reset");
        step();
        step();
        rst = 1'b0;

        // basic order
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = 16'(i + 1);
            step();
            chk("basic_usedw", 32'(bus.usedw), 32'(i + 1));
            chk("basic_valid", 32'(bus.dout_valid), (i >= 2) ? 1 : 0);
            if (i >= 2) chk("basic_head", 32'(bus.dout), 1);
        end
        bus.wr_en = 1'b0;
        step();
        chk("basic_usedw5", 32'(bus.usedw), 5);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("basic_pop_valid", 32'(bus.dout_valid), 1);
            chk("basic_pop_data", 32'(bus.dout), 32'(i + 1));
            step();
        end
        bus.rd_en = 1'b0;
        chk("basic_end_valid", 32'(bus.dout_valid), 0);
        chk("basic_end_empty", 32'(bus.empty), 1);
        chk("basic_end_usedw", 32'(bus.usedw), 0);

        // fill past capacity
        for (int i = 0; i < 20; i++) begin
            int u;
            u = (i + 1 > N) ? N : i + 1;
            bus.wr_en = 1'b1;
            bus.din   = 16'(16'h100 + i);
            step();
            chk("fill_usedw", 32'(bus.usedw), 32'(u));
            chk("fill_full", 32'(bus.full), (u == N) ? 1 : 0);
            chk("fill_af", 32'(bus.almost_full), (u >= 8) ? 1 : 0);
            chk("fill_ae", 32'(bus.almost_empty), (u <= 8) ? 1 : 0);
        end
        bus.wr_en = 1'b0;
        step();
        chk("fill_head", 32'(bus.dout), 32'h100);

        // push+pop while full
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 16'hDEAD;
        step();
        chk("fullpp_usedw", 32'(bus.usedw), 15);
        chk("fullpp_full", 32'(bus.full), 0);
        chk("fullpp_head", 32'(bus.dout), 32'h101);
        bus.din = 16'hBEEF;
        step();
        chk("fullpp2_usedw", 32'(bus.usedw), 15);
        chk("fullpp2_head", 32'(bus.dout), 32'h102);
        bus.wr_en = 1'b0;
        exp_q = {};
        for (int i = 2; i < 16; i++) exp_q.push_back(16'(16'h100 + i));
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 15; i++) begin
            chk("drain_valid", 32'(bus.dout_valid), 1);
            chk("drain_data", 32'(bus.dout), 32'(exp_q[i]));
            step();
        end
        bus.rd_en = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_usedw", 32'(bus.usedw), 0);

        // streaming with pointer wrap
        for (int e = 0; e < 50; e++) begin
            bus.wr_en = (e < 48);
            bus.din   = 16'(16'h200 + e);
            bus.rd_en = bus.dout_valid;
            step();
            if (e >= 2) begin
                chk("strm_valid", 32'(bus.dout_valid), 1);
                chk("strm_data", 32'(bus.dout), 32'(16'h200 + e - 2));
            end
            if (e >= 2 && e <= 47)
                chk("strm_usedw", 32'(bus.usedw), 3);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        step();
        chk("strm_end_empty", 32'(bus.empty), 1);
        chk("strm_end_usedw", 32'(bus.usedw), 0);

        // pop on empty, then one push with rd_en held
        for (int i = 0; i < 3; i++) begin
            step();
            chk("epop_usedw", 32'(bus.usedw), 0);
            chk("epop_empty", 32'(bus.empty), 1);
        end
        bus.wr_en = 1'b1;
        bus.din   = 16'h0055;
        step();
        bus.wr_en = 1'b0;
        chk("epop_k_usedw", 32'(bus.usedw), 1);
        chk("epop_k_valid", 32'(bus.dout_valid), 0);
        step();
        chk("epop_k1_valid", 32'(bus.dout_valid), 0);
        step();
        chk("epop_k2_valid", 32'(bus.dout_valid), 1);
        chk("epop_k2_data", 32'(bus.dout), 32'h55);
        step();
        chk("epop_k3_valid", 32'(bus.dout_valid), 0);
        chk("epop_k3_usedw", 32'(bus.usedw), 0);
        bus.rd_en = 1'b0;

        // asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = 16'(16'h300 + i);
            step();
        end
        bus.wr_en = 1'b0;
        step();
        step();
        chk("mrst_pre_usedw", 32'(bus.usedw), 10);
        chk("mrst_pre_head", 32'(bus.dout), 32'h300);
        #3;
        rst = 1'b1;
        #1;
        chk_rst_vals("mrst");
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 16'h0077;
        step();
        chk("mrst_hold_usedw", 32'(bus.usedw), 0);
        chk("mrst_hold_valid", 32'(bus.dout_valid), 0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #3;
        rst = 1'b0;
        step();
        bus.wr_en = 1'b1;
        bus.din   = 16'h00AA;
        step();
        bus.wr_en = 1'b0;
        step();
        step();
        chk("mrst_aa_valid", 32'(bus.dout_valid), 1);
        chk("mrst_aa_data", 32'(bus.dout), 32'hAA);
        chk("mrst_aa_usedw", 32'(bus.usedw), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
